seq_alu: RTL
============

# seq_alu

Parametrised, multi-cycle successor to the phase-1 combinational ALU. It executes single-cycle logic, arithmetic and shift operations, plus iterative signed multiply (radix-2 Booth) and signed divide (non-restoring), behind a start/done handshake. It sits between the operand registers (RA/RB path) and the Z register, and drives `result_hi`/`result_lo` directly into Z-high/Z-low.

## Interface
- `WIDTH`, 32: operand and result width; must be even and ≥ 8.
- `SHW`, $clog2(WIDTH): width of the shift amount taken from `rb`.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  5  operation code, from the shared package.
- `ra`  in  WIDTH  operand A; captured at accept.
- `rb`  in  WIDTH  operand B; captured at accept.
- `busy`  out  1  high while a multi-cycle operation is in flight.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `result_hi`  out  WIDTH  high product word or remainder; 0 for all other ops.
- `result_lo`  out  WIDTH  low product word, quotient, or single-cycle result.
- `div_by_zero`  out  1  set with `done` on a DIV with rb = 0; held until the next accept.

## Operation
- Op codes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, ADDI 01100, ANDI 01101, ORI 01110, DIV 01111, MUL 10000, NEG 10001, NOT 10010.
- ADDI, ANDI and ORI behave exactly like ADD, AND and OR. The immediate arrives already extended on `rb`.
- NEG and NOT operate on `rb`. ADD and SUB wrap modulo 2^WIDTH; there is no carry or overflow output.
- Shifts and rotates use `rb[SHW-1:0]`. SHRA replicates the sign bit. A shift amount of 0 passes `ra` through unchanged.
- Any undefined op is accepted as a single-cycle op and returns hi = lo = 0.
- MUL is signed × signed and produces a 2·WIDTH-bit product. min × min = +2^(2·WIDTH−2), with no overflow.
- DIV is signed. The quotient truncates toward zero and the remainder takes the sign of the dividend.
- DIV min / −1: quotient = min, remainder = 0.
- DIV with rb = 0: result_lo = all ones, result_hi = ra, `div_by_zero` = 1. Completes as a single-cycle op.
- FSM states:
  - IDLE: start & single-cycle op → write results, pulse `done`, stay in IDLE. start & MUL → MUL_IT. start & DIV with rb ≠ 0 → DIV_IT.
  - MUL_IT: WIDTH iterations. The last iteration writes results, pulses `done`, and returns to IDLE.
  - DIV_IT: WIDTH iterations on magnitudes, then → DIV_FIX.
  - DIV_FIX: restore the final remainder, apply quotient and remainder signs, write results, pulse `done`, return to IDLE.
- Accept writes `div_by_zero` and, for multi-cycle ops, clears both result registers. `start` in any state other than IDLE is ignored; there is no queuing.
- Results and `div_by_zero` hold their values until the next accept.

## Timing
- Reset: `clear` high at an edge forces IDLE and sets `busy` = 0, `done` = 0, `result_hi` = 0, `result_lo` = 0, `div_by_zero` = 0, and clears the iteration counter. This applies in every state, so a multi-cycle op is aborted and discarded. `clear` has priority over `start` in the same cycle.
- Call the cycle in which `start` is sampled high in IDLE "cycle 0".
- Single-cycle ops and DIV-by-zero: `done` = 1 in cycle 1. A new `start` is accepted in cycle 1 (back-to-back).
- MUL: `busy` = 1 in cycles 1..WIDTH, `done` = 1 in cycle WIDTH+1 with `busy` = 0.
- DIV: `busy` = 1 in cycles 1..WIDTH+1, `done` = 1 in cycle WIDTH+2 with `busy` = 0.
- `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE.
- `ra`, `rb` and `op` may change freely after cycle 0.

## Structure
- `alu_pkg` holds: the op-code localparams, the FSM state enum, and the default WIDTH.
- One combinational sub-module, `shift_unit` (WIDTH, SHW), covers SHR, SHRA, SHL, ROR and ROL.
- The FSM, the Booth accumulator/multiplier register pair, the divider remainder/quotient pair, and the counter all live in `seq_alu`. The counter is SHW+1 bits wide.

## Test plan
- ADD 7 + 0xFFFFFFFD → lo = 4, hi = 0, `done` in cycle 1. Then SUB 3 − 5 back-to-back in cycle 1 → lo = 0xFFFFFFFE.
- MUL −6 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFD6, `done` in cycle 33. Also 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV −17 / 5 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFE, `done` in cycle 34. Also 17 / −5 → lo = 0xFFFFFFFD, hi = 2.
- DIV 9 / 0 → `div_by_zero` = 1, lo = 0xFFFFFFFF, hi = 9, `done` in cycle 1. The next ADD clears the flag.
- ROR 0x80000001 by 1 → 0xC0000000. SHRA 0x80000000 by 4 → 0xF8000000. ROL by 0 → unchanged.
- MUL started, `start`+ADD pulsed in cycle 5 → ignored. `clear` in cycle 10 → in cycle 11 `busy` = 0, results = 0, and no `done` follows.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state encoding
// and the default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_IT  = 2'd1,
        DIV_IT  = 2'd2,
        DIV_FIX = 2'd3
    } state_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational shifter/rotator for SHR, SHRA, SHL, ROR and ROL.
// Non-shift op codes produce zero.
module shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] ror_y;
    logic [WIDTH-1:0] rol_y;

    // A zero amount would make the complementary shift a full-width shift.
    assign ror_y = (amt == '0) ? a : ((a >> amt) | (a << (WIDTH - int'(amt))));
    assign rol_y = (amt == '0) ? a : ((a << amt) | (a >> (WIDTH - int'(amt))));

    always_comb begin
        y = '0;
        case (op)
            OP_SHR:  y = a >> amt;
            OP_SHRA: y = $unsigned($signed(a) >>> amt);
            OP_SHL:  y = a << amt;
            OP_ROR:  y = ror_y;
            OP_ROL:  y = rol_y;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus Booth signed
// multiply and non-restoring signed divide behind a start/done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    // Handshake: start is taken only in IDLE (busy low); the accept edge
    // captures op/ra/rb, and done pulses for exactly one cycle when results
    // land. A start seen while busy is dropped, never queued.

    state_t             state;
    logic [SHW:0]       cnt;
    logic [WIDTH:0]     opnd;      // sign-extended multiplicand or divisor magnitude
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   mq;
    logic               q_1;
    logic [WIDTH+1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic               neg_q;
    logic               neg_r;

    logic [WIDTH-1:0]   shift_y;
    logic [WIDTH-1:0]   single_lo;
    logic [WIDTH-1:0]   abs_ra;
    logic [WIDTH-1:0]   abs_rb;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   mq_next;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_it;

    shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
        .op  (op),
        .a   (ra),
        .amt (rb[SHW-1:0]),
        .y   (shift_y)
    );

    always_comb begin
        single_lo = '0;
        case (op)
            OP_ADD, OP_ADDI: single_lo = ra + rb;
            OP_SUB:          single_lo = ra - rb;
            OP_AND, OP_ANDI: single_lo = ra & rb;
            OP_OR,  OP_ORI:  single_lo = ra | rb;
            OP_NEG:          single_lo = -rb;
            OP_NOT:          single_lo = ~rb;
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: single_lo = shift_y;
            default:         single_lo = '0;
        endcase
    end

    assign abs_ra  = ra[WIDTH-1] ? -ra : ra;
    assign abs_rb  = rb[WIDTH-1] ? -rb : rb;
    assign last_it = (cnt == (SHW+1)'(WIDTH-1));

    // The extra accumulator bit keeps min x min from overflowing the add step.
    always_comb begin
        booth_sum = acc;
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + opnd;
            2'b10:   booth_sum = acc - opnd;
            default: booth_sum = acc;
        endcase
    end
    assign acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign mq_next  = {booth_sum[0], mq[WIDTH-1:1]};

    assign div_shift = {rem[WIDTH:0], quo[WIDTH-1]};
    assign rem_next  = rem[WIDTH+1] ? div_shift + {1'b0, opnd}
                                    : div_shift - {1'b0, opnd};
    assign quo_next  = {quo[WIDTH-2:0], ~rem_next[WIDTH+1]};
    // The corrected remainder is below the divisor, so WIDTH bits suffice.
    assign rem_fix   = rem[WIDTH+1] ? rem[WIDTH-1:0] + opnd[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            opnd        <= '0;
            acc         <= '0;
            mq          <= '0;
            q_1         <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        if (op == OP_MUL) begin
                            state     <= MUL_IT;
                            busy      <= 1'b1;
                            result_hi <= '0;
                            result_lo <= '0;
                            acc       <= '0;
                            mq        <= rb;
                            q_1       <= 1'b0;
                            opnd      <= {ra[WIDTH-1], ra};
                        end else if (op == OP_DIV && rb != '0) begin
                            state     <= DIV_IT;
                            busy      <= 1'b1;
                            result_hi <= '0;
                            result_lo <= '0;
                            rem       <= '0;
                            quo       <= abs_ra;
                            opnd      <= {1'b0, abs_rb};
                            neg_q     <= ra[WIDTH-1] ^ rb[WIDTH-1];
                            neg_r     <= ra[WIDTH-1];
                        end else if (op == OP_DIV) begin
                            result_hi   <= ra;
                            result_lo   <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            result_hi <= '0;
                            result_lo <= single_lo;
                            done      <= 1'b1;
                        end
                    end
                end
                MUL_IT: begin
                    acc <= acc_next;
                    mq  <= mq_next;
                    q_1 <= mq[0];
                    cnt <= cnt + 1'b1;
                    if (last_it) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result_hi <= acc_next[WIDTH-1:0];
                        result_lo <= mq_next;
                    end
                end
                DIV_IT: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (last_it) state <= DIV_FIX;
                end
                DIV_FIX: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    result_lo <= neg_q ? -quo : quo;
                    result_hi <= neg_r ? -rem_fix : rem_fix;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
